// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side arbiter and its round-robin picker.
package fifo_pkg;

    // Arbiter FSM encoding.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Width of an index into n requesters (at least one bit).
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a burst counter that can represent 0..max_burst.
    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: finds the first set request bit
// searching upward from (last_grant + 1), wrapping at NUM_REQ.
module rr_pick
    import fifo_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic               any,
    output logic [ID_W-1:0]    winner
);

    // Scan the rotated request vector; the first hit wins.
    always_comb begin
        int idx;
        // NOTE: every variable gets a default before any conditional
        // assignment, otherwise the paths that skip it infer a latch.
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(last_grant) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any && req[idx[ID_W-1:0]]) begin
                any    = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NUM_REQ
// producers. A grant lasts until the owner drops req or writes MAX_BURST
// words; writes stall (state held) while the FIFO reports full.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter  int FIFO_WIDTH = 16,
    parameter  int NUM_REQ    = 4,
    parameter  int MAX_BURST  = 8,
    localparam int ID_W       = id_width(NUM_REQ),
    localparam int CNT_W      = cnt_width(MAX_BURST)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] din,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          fifo_full,
    output logic                          fifo_wen,
    output logic [FIFO_WIDTH-1:0]         fifo_din,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);

    localparam logic [CNT_W-1:0] LAST_BEAT    = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]  LAST_ID_INIT = ID_W'(NUM_REQ - 1);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]    last_q,  last_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               pick_any;
    logic [ID_W-1:0]    pick_id;

    rr_pick #(
        .NUM_REQ    (NUM_REQ)
    ) u_pick (
        .req        (req),
        .last_grant (last_q),
        .any        (pick_any),
        .winner     (pick_id)
    );

    assign grant_id = grant_q;

    // Write-port outputs: purely a function of registered owner and live inputs.
    always_comb begin
        busy           = (state_q == GRANT);
        fifo_wen       = busy & req[grant_q] & ~fifo_full;
        ack            = '0;
        ack[grant_q]   = fifo_wen;
        fifo_din       = din[int'(grant_q)*FIFO_WIDTH +: FIFO_WIDTH];
    end

    // Next-state: arbitrate in IDLE, count beats and decide exit in GRANT.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    grant_d = pick_id;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (!req[grant_q]) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end else if (fifo_wen) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // State registers; reset points last_grant at the top so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_ID_INIT;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values
            // regardless of statement order.
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a 4x8 build checked against a
// scoreboard of expected FIFO writes, plus a 2x1 build checked for alternation.
module tb_fifo_wr_arbiter;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int MB = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main build
    logic [N-1:0]   req;
    logic [N*W-1:0] din;
    logic [N-1:0]   ack;
    logic           fifo_full;
    logic           fifo_wen;
    logic [W-1:0]   fifo_din;
    logic [1:0]     grant_id;
    logic           busy;

    // Two-requester, single-word-burst build
    logic [1:0]     req_b;
    logic [2*W-1:0] din_b;
    logic [1:0]     ack_b;
    logic           full_b;
    logic           fifo_wen_b;
    logic [W-1:0]   fifo_din_b;
    logic [0:0]     grant_id_b;
    logic           busy_b;

    fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .ack       (ack),
        .fifo_full (fifo_full),
        .fifo_wen  (fifo_wen),
        .fifo_din  (fifo_din),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    fifo_wr_arbiter #(.FIFO_WIDTH(W), .NUM_REQ(2), .MAX_BURST(1)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .req       (req_b),
        .din       (din_b),
        .ack       (ack_b),
        .fifo_full (full_b),
        .fifo_wen  (fifo_wen_b),
        .fifo_din  (fifo_din_b),
        .grant_id  (grant_id_b),
        .busy      (busy_b)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           id;
        logic [W-1:0] word;
    } beat_t;

    beat_t exp_q[$];
    int    prod_k[N];   // words consumed per producer, as seen through ack
    int    exp_k[N];    // words expected per producer, as queued by stimulus

    function automatic logic [W-1:0] word_of(input int id, input int k);
        return W'(32'hA000 + id * 32'h1000 + k);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Producers present their next word until it is acked.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            din[i*W +: W] = word_of(i, prod_k[i]);
        end
    end

    // FIFO side: every write is popped against the scoreboard.
    always @(negedge clk) begin
        beat_t b;
        if (fifo_wen === 1'b1) begin
            check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                check("sb_id",   32'(grant_id), 32'(b.id));
                check("sb_ack",  32'(ack), 32'd1 << b.id);
                check("sb_data", 32'(fifo_din), 32'(b.word));
            end
            for (int i = 0; i < N; i++) begin
                if (ack[i]) prod_k[i]++;
            end
        end else begin
            check("idle_ack", 32'(ack), 32'd0);
        end
    end

    task automatic push(input int id, input int n);
        for (int j = 0; j < n; j++) begin
            exp_q.push_back('{id, word_of(id, exp_k[id])});
            exp_k[id]++;
        end
    endtask

    // One cycle: observe at negedge, then advance to just after the next posedge.
    task automatic cyc(input string tag, input logic ew, input logic eb);
        @(negedge clk);
        check({tag, "_wen"},  32'(fifo_wen), 32'(ew));
        check({tag, "_busy"}, 32'(busy), 32'(eb));
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_b(input logic ew, input int id);
        @(negedge clk);
        check("b_wen",  32'(fifo_wen_b), 32'(ew));
        check("b_busy", 32'(busy_b), 32'(ew));
        if (ew) begin
            check("b_id",   32'(grant_id_b), 32'(id));
            check("b_ack",  32'(ack_b), 32'd1 << id);
            check("b_data", 32'(fifo_din_b), (id == 1) ? 32'h2222 : 32'h1111);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            prod_k[i] = 0;
            exp_k[i]  = 0;
        end
        rst       = 1'b1;
        req       = '0;
        fifo_full = 1'b0;
        req_b     = '0;
        din_b     = {16'h2222, 16'h1111};
        full_b    = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        check("rst_ack",   32'(ack), 32'd0);
        check("rst_wen",   32'(fifo_wen), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_id",    32'(grant_id), 32'd0);
        check("rst_din",   32'(fifo_din), 32'hA000);
        check("rst_busyb", 32'(busy_b), 32'd0);
        rst = 1'b0;

        // Single producer: 8-word burst, one bubble, re-grant to 0
        req = 4'b0001;
        push(0, 9);
        cyc("t1_c0", 1'b0, 1'b0);
        for (int c = 1; c <= 8; c++) cyc("t1_burst", 1'b1, 1'b1);
        cyc("t1_bubble", 1'b0, 1'b0);
        cyc("t1_regrant", 1'b1, 1'b1);
        req = 4'b0000;
        cyc("t1_drop", 1'b0, 1'b1);
        cyc("t1_idle", 1'b0, 1'b0);

        // All requesting: order 0,1,2,3,0, 8 words each, one bubble between
        do_reset();
        req = 4'b1111;
        push(0, MB); push(1, MB); push(2, MB); push(3, MB); push(0, MB);
        for (int c = 0; c <= 44; c++) begin
            cyc("t2", (c >= 1) && (c % 9 != 0), (c >= 1) && (c % 9 != 0));
        end
        req = 4'b0000;
        cyc("t2_end", 1'b0, 1'b0);

        // Owner 2 drops after 3 words; next grant is 3 even though 0 requests
        do_reset();
        req = 4'b1100;
        push(2, 3);
        push(3, MB);
        cyc("t3_c0", 1'b0, 1'b0);
        for (int c = 1; c <= 3; c++) cyc("t3_own2", 1'b1, 1'b1);
        req = 4'b1001;
        cyc("t3_drop", 1'b0, 1'b1);
        cyc("t3_bubble", 1'b0, 1'b0);
        for (int c = 6; c <= 13; c++) cyc("t3_own3", 1'b1, 1'b1);
        req = 4'b0000;
        cyc("t3_end", 1'b0, 1'b0);

        // FIFO full for burst cycles 4..9: stall, then finish the 8 words
        do_reset();
        req = 4'b0001;
        push(0, MB);
        cyc("t4_c0", 1'b0, 1'b0);
        for (int c = 1; c <= 3; c++) cyc("t4_pre", 1'b1, 1'b1);
        fifo_full = 1'b1;
        for (int c = 4; c <= 9; c++) cyc("t4_full", 1'b0, 1'b1);
        fifo_full = 1'b0;
        for (int c = 10; c <= 14; c++) cyc("t4_post", 1'b1, 1'b1);
        req = 4'b0000;
        cyc("t4_end", 1'b0, 1'b0);

        // Req drops in the same cycle full rises: exit without a write
        req = 4'b0001;
        push(0, 1);
        cyc("t5_c0", 1'b0, 1'b0);
        cyc("t5_w", 1'b1, 1'b1);
        req       = 4'b0000;
        fifo_full = 1'b1;
        cyc("t5_drop", 1'b0, 1'b1);
        cyc("t5_idle", 1'b0, 1'b0);
        fifo_full = 1'b0;

        // Asynchronous reset mid-burst, then requester 0 wins first
        req = 4'b0001;
        push(0, 2);
        cyc("t6_c0", 1'b0, 1'b0);
        cyc("t6_w", 1'b1, 1'b1);
        cyc("t6_w", 1'b1, 1'b1);
        check("t6_pre_wen", 32'(fifo_wen), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_wen",  32'(fifo_wen), 32'd0);
        check("t6_rst_ack",  32'(ack), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 4'b1111;
        push(0, 1);
        cyc("t6_c0b", 1'b0, 1'b0);
        cyc("t6_first", 1'b1, 1'b1);
        req = 4'b0000;
        cyc("t6_drop", 1'b0, 1'b1);
        cyc("t6_idle", 1'b0, 1'b0);

        // NUM_REQ=2, MAX_BURST=1: strict alternation with a bubble between
        req_b = 2'b11;
        cyc_b(1'b0, 0);
        for (int c = 1; c <= 8; c++) begin
            cyc_b((c % 2) == 1, ((c - 1) / 2) % 2);
        end
        req_b = 2'b00;

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
